anode_scan_ctrl: RTL and testbench

//  Parametrised multiplexed-display scan controller for the board's common-anode 7-segment banks.

---
 rtl/anode_scan_ctrl.sv | 75 +++++++
 tb/tb_anode_scan_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/anode_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller: slot prescaler, digit walker,
// and registered active-low anode drive with guard band, blanking and 16-level dimming.
module anode_scan_ctrl #(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned GUARD    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [$clog2(NDIG+1)-1:0]  n_active,
  input  logic [NDIG-1:0]            digit_en,
  input  logic [3:0]                 dim,
  output logic [$clog2(NDIG)-1:0]    digit_sel,
  output logic                       scan_tick,
  output logic [NDIG-1:0]            an_l
);

  localparam int unsigned CW    = $clog2(PRESCALE);
  localparam int unsigned PW    = $clog2(PRESCALE + 1);
  localparam int unsigned IW    = $clog2(NDIG);
  localparam int unsigned NW    = $clog2(NDIG + 1);
  localparam int unsigned SLICE = PRESCALE / 16;

  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;

  logic [NW-1:0]   n_eff_c;
  logic            wrap_c;
  logic [PW-1:0]   lim_c;
  logic            on_c;
  logic            idx_live_c;
  logic [NDIG-1:0] req_c;

  // Effective digit count, slot boundary and brightness window.
  always_comb begin
    n_eff_c    = (n_active > NW'(NDIG)) ? NW'(NDIG) : n_active;
    wrap_c     = (cnt == CW'(PRESCALE - 1));
    lim_c      = PW'((32'(dim) + 32'd1) * SLICE);
    on_c       = (PW'(cnt) >= PW'(GUARD)) && (PW'(cnt) < lim_c);
    idx_live_c = (n_eff_c != '0) && (NW'(idx) < n_eff_c);
  end

  // Anode request: at most one bit low, blanked outside the window or when disabled.
  always_comb begin
    req_c = '1;
    if (en && idx_live_c && digit_en[idx] && on_c) begin
      req_c = ~(NDIG'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
      an_l      <= '1;
    end else begin
      cnt       <= wrap_c ? '0 : cnt + CW'(1);
      scan_tick <= wrap_c && (n_eff_c != '0);
      an_l      <= req_c;
      // A shrunken n_active pulls an out-of-range idx back to 0 at the boundary.
      if (wrap_c) begin
        if ((n_eff_c == '0) || (NW'(idx) >= n_eff_c - NW'(1))) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign digit_sel = idx;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Directed bench for anode_scan_ctrl with NDIG=8, PRESCALE=16, GUARD=2.
module tb_anode_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] n_active;
  logic [7:0] digit_en;
  logic [3:0] dim;
  logic [2:0] digit_sel;
  logic       scan_tick;
  logic [7:0] an_l;

  int n_chk  = 0;
  int n_fail = 0;

  anode_scan_ctrl #(.NDIG(8), .PRESCALE(16), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .n_active  (n_active),
    .digit_en  (digit_en),
    .dim       (dim),
    .digit_sel (digit_sel),
    .scan_tick (scan_tick),
    .an_l      (an_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at cnt=0 of a slot. an_l lags the counter by one cycle, so cnt=c shows the
  // request made at cnt=c-1: lit for c in [3, lim] where lim=(dim+1) for SLICE=1.
  task automatic run_slot(input string tag, input logic [7:0] prev, input logic [7:0] cur,
                          input logic [2:0] sel, input int lim, input logic tk);
    chk({tag, "_an0"}, an_l, prev);
    chk({tag, "_sel0"}, 8'(digit_sel), 8'(sel));
    chk({tag, "_tick0"}, 8'(scan_tick), 8'(tk));
    for (int c = 1; c < 16; c++) begin
      step();
      chk($sformatf("%s_an%0d", tag, c), an_l, (c >= 3 && c <= lim) ? cur : 8'hFF);
      chk($sformatf("%s_sel%0d", tag, c), 8'(digit_sel), 8'(sel));
      chk($sformatf("%s_tick%0d", tag, c), 8'(scan_tick), 8'h00);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; n_active = 4'd3; digit_en = 8'hFF; dim = 4'd15;

    // Reset state
    repeat (3) step();
    chk("rst_an", an_l, 8'hFF);
    chk("rst_sel", 8'(digit_sel), 8'h00);
    chk("rst_tick", 8'(scan_tick), 8'h00);
    rst = 1'b0;

    // Three-digit scan at full brightness
    run_slot("s0", 8'hFF, 8'hFE, 3'd0, 16, 1'b0);
    run_slot("s1", 8'hFE, 8'hFD, 3'd1, 16, 1'b1);
    run_slot("s2", 8'hFD, 8'hFB, 3'd2, 16, 1'b1);
    run_slot("s0b", 8'hFB, 8'hFE, 3'd0, 16, 1'b1);

    // Grow to 4 digits, then shrink to 2 while digit 3 is on
    n_active = 4'd4;
    run_slot("g1", 8'hFE, 8'hFD, 3'd1, 16, 1'b1);
    run_slot("g2", 8'hFD, 8'hFB, 3'd2, 16, 1'b1);
    chk("g3_an0", an_l, 8'hFB);
    chk("g3_sel0", 8'(digit_sel), 8'h03);
    chk("g3_tick0", 8'(scan_tick), 8'h01);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("g3_an%0d", c), an_l, (c >= 3) ? 8'hF7 : 8'hFF);
    end
    n_active = 4'd2;
    for (int c = 5; c <= 15; c++) begin
      step();
      chk($sformatf("shr_an%0d", c), an_l, 8'hFF);
      chk($sformatf("shr_sel%0d", c), 8'(digit_sel), 8'h03);
    end
    step();
    run_slot("shr_next", 8'hFF, 8'hFE, 3'd0, 16, 1'b1);

    // Dimming: dim=7 lights 6 cycles, dim=0 never lights
    dim = 4'd7;
    run_slot("dim7", 8'hFE, 8'hFD, 3'd1, 8, 1'b1);
    dim = 4'd0;
    run_slot("dim0", 8'hFF, 8'hFE, 3'd0, 1, 1'b1);

    // Per-digit blanking of digit 1
    dim = 4'd15; digit_en = 8'hFD; n_active = 4'd3;
    run_slot("blk1", 8'hFF, 8'hFF, 3'd1, 16, 1'b1);
    run_slot("blk2", 8'hFF, 8'hFB, 3'd2, 16, 1'b1);
    run_slot("blk0", 8'hFB, 8'hFE, 3'd0, 16, 1'b1);
    run_slot("blk1b", 8'hFE, 8'hFF, 3'd1, 16, 1'b1);

    // Global disable mid-slot; scan keeps running
    digit_en = 8'hFF;
    chk("en_an0", an_l, 8'hFF);
    chk("en_sel0", 8'(digit_sel), 8'h02);
    chk("en_tick0", 8'(scan_tick), 8'h01);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("en_an%0d", c), an_l, (c >= 3) ? 8'hFB : 8'hFF);
    end
    en = 1'b0;
    for (int c = 5; c <= 15; c++) begin
      step();
      chk($sformatf("dis_an%0d", c), an_l, 8'hFF);
      chk($sformatf("dis_sel%0d", c), 8'(digit_sel), 8'h02);
    end
    step();
    run_slot("dis0", 8'hFF, 8'hFF, 3'd0, 16, 1'b1);

    // Zero active digits: blank, idx returns to 0 and stays, no ticks
    en = 1'b1; n_active = 4'd0;
    run_slot("z1", 8'hFF, 8'hFF, 3'd1, 16, 1'b1);
    run_slot("z0a", 8'hFF, 8'hFF, 3'd0, 16, 1'b0);
    run_slot("z0b", 8'hFF, 8'hFF, 3'd0, 16, 1'b0);

    // Reset mid-slot while digit 1 is lit
    n_active = 4'd3;
    run_slot("pr0", 8'hFF, 8'hFE, 3'd0, 16, 1'b0);
    repeat (4) step();
    chk("pr1_an4", an_l, 8'hFD);
    chk("pr1_sel4", 8'(digit_sel), 8'h01);
    rst = 1'b1; n_active = 4'd15;
    step();
    chk("mrst_an", an_l, 8'hFF);
    chk("mrst_sel", 8'(digit_sel), 8'h00);
    chk("mrst_tick", 8'(scan_tick), 8'h00);
    rst = 1'b0;

    // n_active above NDIG saturates to all 8 digits
    run_slot("sat0", 8'hFF, 8'hFE, 3'd0, 16, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] one;
      one = 8'h01;
      run_slot($sformatf("sat%0d", i), ~(one << ((i - 1) % 8)), ~(one << (i % 8)),
               3'(i % 8), 16, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
